// File: rtl/uart_fifo_periph_if.sv
// Bus bundle for the UART peripheral: select, read enable, byte strobes,
// word address, and write/read data.
interface uart_fifo_periph_if;
   logic        cs;
   logic        oe;
   logic [3:0]  wstrb;
   logic [3:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;

   modport master (output cs, oe, wstrb, addr, data_in, input data_out);
   modport slave  (input cs, oe, wstrb, addr, data_in, output data_out);
endinterface

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART with TX/RX FIFOs, 1/2 stop bits, RX glitch rejection,
// internal loopback, sticky W1C error flags and a maskable level interrupt.
module uart_fifo_periph #(
   parameter int FIFO_DEPTH = 16,
   parameter int BRR_W      = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   uart_fifo_periph_if.slave bus,
   input  logic              rxd,
   output logic              txd,
   output logic              irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

   logic [BRR_W-1:0] brr;
   logic             tx_en, rx_en, two_stop, loopback;
   logic [2:0]       irq_en;
   logic [CNT_W-1:0] rx_thr;
   logic             fe, rx_ovr, tx_ovf;
   logic             rd_q;

   logic [7:0]       tx_mem [FIFO_DEPTH];
   logic [AW-1:0]    tx_wp, tx_rp;
   logic [CNT_W-1:0] tx_count;
   logic [7:0]       rx_mem [FIFO_DEPTH];
   logic [AW-1:0]    rx_wp, rx_rp;
   logic [CNT_W-1:0] rx_count;

   tx_state_t        tx_state, tx_state_n;
   logic [BRR_W-1:0] tx_cnt, tx_cnt_n;
   logic [7:0]       tx_shift, tx_shift_n;
   logic [2:0]       tx_idx, tx_idx_n;
   logic             tx_pop, tx_bit, tx_load;

   rx_state_t        rx_state, rx_state_n;
   logic [BRR_W-1:0] rx_cnt, rx_cnt_n;
   logic [7:0]       rx_shift, rx_shift_n;
   logic [2:0]       rx_idx, rx_idx_n;
   logic [1:0]       rx_sync;
   logic             rx_prev, rx_in, rx_push_req, rx_frame_err;

   logic        wr0, rd_term, rx_pop, tx_flush, rx_flush, w1c;
   logic        tx_empty, tx_full, rx_empty, rx_full, tx_push, rx_push;
   logic [31:0] wmask;
   logic        unused_ok;

   assign wr0      = bus.cs && bus.wstrb[0];
   assign rd_term  = bus.cs && bus.oe && (bus.addr == 4'd0);
   assign tx_flush = wr0 && (bus.addr == 4'd3) && bus.data_in[5];
   assign rx_flush = wr0 && (bus.addr == 4'd3) && bus.data_in[4];
   assign w1c      = wr0 && (bus.addr == 4'd1);
   assign wmask    = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}}, {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
   assign unused_ok = ^{bus.data_in, wmask};

   assign tx_empty = (tx_count == '0);
   assign tx_full  = (tx_count == FULL_CNT);
   assign rx_empty = (rx_count == '0);
   assign rx_full  = (rx_count == FULL_CNT);
   assign tx_push  = wr0 && (bus.addr == 4'd0) && !tx_full && !tx_flush;
   assign rx_push  = rx_push_req && !rx_full && !rx_flush;
   assign rx_pop   = rd_term && !rd_q && !rx_empty;
   assign tx_load  = tx_en && !tx_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         brr      <= '0;
         tx_en    <= 1'b0;
         rx_en    <= 1'b0;
         two_stop <= 1'b0;
         loopback <= 1'b0;
         irq_en   <= '0;
         rx_thr   <= '0;
      end else if (bus.cs) begin
         if (bus.addr == 4'd2)
            brr <= (brr & ~wmask[BRR_W-1:0]) | (bus.data_in[BRR_W-1:0] & wmask[BRR_W-1:0]);
         if (wr0 && bus.addr == 4'd3)
            {loopback, two_stop, rx_en, tx_en} <= bus.data_in[3:0];
         if (wr0 && bus.addr == 4'd4)
            irq_en <= bus.data_in[2:0];
         if (wr0 && bus.addr == 4'd5)
            rx_thr <= bus.data_in[CNT_W-1:0];
      end
   end

   // Clears are applied first so a same-cycle error event keeps its flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fe     <= 1'b0;
         rx_ovr <= 1'b0;
         tx_ovf <= 1'b0;
      end else begin
         if (w1c && bus.data_in[5]) fe     <= 1'b0;
         if (w1c && bus.data_in[6]) rx_ovr <= 1'b0;
         if (w1c && bus.data_in[7]) tx_ovf <= 1'b0;
         if (rx_frame_err) fe <= 1'b1;
         if (rx_push_req && rx_full && !rx_flush) rx_ovr <= 1'b1;
         if (wr0 && bus.addr == 4'd0 && tx_full) tx_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= 1'b0;
         irq  <= 1'b0;
      end else begin
         rd_q <= rd_term;
         irq  <= (irq_en[0] && (rx_thr != '0) && (rx_count >= rx_thr)) ||
                 (irq_en[1] && tx_empty) ||
                 (irq_en[2] && (fe || rx_ovr || tx_ovf));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || tx_flush) begin
         tx_wp    <= '0;
         tx_rp    <= '0;
         tx_count <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || rx_flush) begin
         rx_wp    <= '0;
         rx_rp    <= '0;
         rx_count <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
         rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= bus.data_in[7:0];
      if (rx_push) rx_mem[rx_wp] <= rx_shift;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_shift <= '0;
         tx_idx   <= '0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_shift <= tx_shift_n;
         tx_idx   <= tx_idx_n;
      end
   end

   // STOP can load the next byte directly, so consecutive frames have no gap.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_shift_n = tx_shift;
      tx_idx_n   = tx_idx;
      tx_pop     = 1'b0;
      tx_bit     = 1'b1;
      unique case (tx_state)
         TX_IDLE: begin
            if (tx_load) begin
               tx_pop     = 1'b1;
               tx_shift_n = tx_mem[tx_rp];
               tx_cnt_n   = brr;
               tx_state_n = TX_START;
            end
         end
         TX_START: begin
            tx_bit = 1'b0;
            if (tx_cnt == '0) begin
               tx_cnt_n   = brr;
               tx_idx_n   = '0;
               tx_state_n = TX_DATA;
            end else begin
               tx_cnt_n = tx_cnt - 1'b1;
            end
         end
         TX_DATA: begin
            tx_bit = tx_shift[0];
            if (tx_cnt == '0) begin
               tx_cnt_n   = brr;
               tx_shift_n = tx_shift >> 1;
               tx_idx_n   = tx_idx + 3'd1;
               if (tx_idx == 3'd7) begin
                  tx_idx_n   = '0;
                  tx_state_n = TX_STOP;
               end
            end else begin
               tx_cnt_n = tx_cnt - 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt != '0) begin
               tx_cnt_n = tx_cnt - 1'b1;
            end else if (two_stop && tx_idx == 3'd0) begin
               tx_idx_n = 3'd1;
               tx_cnt_n = brr;
            end else if (tx_load) begin
               tx_pop     = 1'b1;
               tx_shift_n = tx_mem[tx_rp];
               tx_cnt_n   = brr;
               tx_state_n = TX_START;
            end else begin
               tx_state_n = TX_IDLE;
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

   assign txd   = loopback ? 1'b1 : tx_bit;
   assign rx_in = loopback ? tx_bit : rx_sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync  <= '0;
         rx_prev  <= 1'b0;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_shift <= '0;
         rx_idx   <= '0;
      end else begin
         rx_sync  <= {rx_sync[0], rxd};
         rx_prev  <= rx_in;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_shift <= rx_shift_n;
         rx_idx   <= rx_idx_n;
      end
   end

   always_comb begin
      rx_state_n   = rx_state;
      rx_cnt_n     = rx_cnt;
      rx_shift_n   = rx_shift;
      rx_idx_n     = rx_idx;
      rx_push_req  = 1'b0;
      rx_frame_err = 1'b0;
      if (!rx_en) begin
         rx_state_n = RX_IDLE;
      end else begin
         unique case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_in) begin
                  rx_cnt_n   = brr >> 1;
                  rx_state_n = RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt != '0) begin
                  rx_cnt_n = rx_cnt - 1'b1;
               end else if (rx_in) begin
                  rx_state_n = RX_IDLE;
               end else begin
                  rx_cnt_n   = brr;
                  rx_idx_n   = '0;
                  rx_state_n = RX_DATA;
               end
            end
            RX_DATA: begin
               if (rx_cnt != '0) begin
                  rx_cnt_n = rx_cnt - 1'b1;
               end else begin
                  rx_shift_n = {rx_in, rx_shift[7:1]};
                  rx_cnt_n   = brr;
                  rx_idx_n   = rx_idx + 3'd1;
                  if (rx_idx == 3'd7) rx_state_n = RX_STOP;
               end
            end
            RX_STOP: begin
               if (rx_cnt != '0) begin
                  rx_cnt_n = rx_cnt - 1'b1;
               end else if (rx_in) begin
                  rx_push_req = 1'b1;
                  rx_state_n  = RX_IDLE;
               end else begin
                  rx_frame_err = 1'b1;
                  rx_state_n   = RX_BREAK;
               end
            end
            RX_BREAK: if (rx_in) rx_state_n = RX_IDLE;
            default: rx_state_n = RX_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.data_out = '0;
      if (bus.cs && bus.oe) begin
         case (bus.addr)
            4'd0: bus.data_out = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
            4'd1: bus.data_out = {24'd0, tx_ovf, rx_ovr, fe,
                                  tx_empty && (tx_state == TX_IDLE),
                                  tx_full, tx_empty, rx_full, rx_empty};
            4'd2: bus.data_out = 32'(brr);
            4'd3: bus.data_out = {28'd0, loopback, two_stop, rx_en, tx_en};
            4'd4: bus.data_out = {29'd0, irq_en};
            4'd5: bus.data_out = 32'(rx_thr);
            4'd6: bus.data_out = {16'(tx_count), 16'(rx_count)};
            default: bus.data_out = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed bench for uart_fifo_periph: RX bytes are checked through a
// scoreboard queue filled when the byte is sent and drained on DATA reads.
module tb_uart_fifo_periph;
   logic clk = 1'b0;
   logic rst;
   logic rxd;
   logic txd;
   logic irq;

   int total = 0;
   int bad = 0;
   int lb_low_cnt = 0;
   logic lb_watch = 1'b0;
   logic [7:0] exp_q[$];
   logic [31:0] d;

   uart_fifo_periph_if bus ();

   uart_fifo_periph #(.FIFO_DEPTH(16), .BRR_W(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .rxd(rxd),
      .txd(txd),
      .irq(irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (lb_watch && txd !== 1'b1) lb_low_cnt++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] v, input logic [3:0] s);
      @(negedge clk);
      bus.cs = 1'b1; bus.oe = 1'b0; bus.addr = a; bus.data_in = v; bus.wstrb = s;
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.wstrb = 4'd0;
   endtask

   // One idle cycle first so the previous read's registered term has dropped.
   task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
      @(negedge clk);
      @(negedge clk);
      bus.cs = 1'b1; bus.oe = 1'b1; bus.addr = a;
      #1 v = bus.data_out;
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.oe = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_clks);
      @(negedge clk);
      rxd = 1'b0;
      repeat (bit_clks) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (bit_clks) @(negedge clk);
      end
      rxd = stop;
      repeat (bit_clks) @(negedge clk);
      rxd = 1'b1;
      repeat (bit_clks) @(negedge clk);
   endtask

   task automatic sb_read(input string tag);
      logic [31:0] e;
      e = 32'hxxxx_xxxx;
      bus_read(4'd0, d);
      if (exp_q.size() != 0) e = {24'd0, exp_q.pop_front()};
      check(tag, d, e);
   endtask

   initial begin
      logic [9:0] frame;
      int n;
      rst = 1'b1; rxd = 1'b1;
      bus.cs = 1'b0; bus.oe = 1'b0; bus.wstrb = 4'd0; bus.addr = 4'd0; bus.data_in = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_irq", {31'd0, irq}, 32'd0);
      @(negedge clk) rst = 1'b0;

      bus.cs = 1'b1; bus.addr = 4'd1;
      #1 check("rdata_no_oe", bus.data_out, 32'd0);
      bus.cs = 1'b0;
      bus_read(4'd1, d); check("rst_status", d, 32'h15);
      bus_read(4'd6, d); check("rst_levels", d, 32'd0);
      bus_read(4'd2, d); check("rst_brr", d, 32'd0);

      // TX frame shape, BRR=3
      bus_write(4'd2, 32'd3, 4'b0011);
      bus_write(4'd3, 32'h1, 4'b0001);
      bus_write(4'd0, 32'hA5, 4'b0001);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("txd_bit%0d_clk%0d", k, c), {31'd0, txd}, {31'd0, frame[k]});
         end
      end
      bus_read(4'd1, d); check("tx_idle_after", d, 32'h15);

      // Loopback of three bytes, BRR=7
      bus_write(4'd2, 32'd7, 4'b0011);
      bus_write(4'd3, 32'hB, 4'b0001);
      lb_watch = 1'b1;
      bus_write(4'd0, 32'h00, 4'b0001); exp_q.push_back(8'h00);
      bus_write(4'd0, 32'h5A, 4'b0001); exp_q.push_back(8'h5A);
      bus_write(4'd0, 32'hFF, 4'b0001); exp_q.push_back(8'hFF);
      n = 0;
      do begin
         bus_read(4'd6, d);
         n++;
      end while (d[15:0] != 16'd3 && n < 300);
      check("lb_levels", d, 32'd3);
      sb_read("lb_data0");
      sb_read("lb_data1");
      sb_read("lb_data2");
      bus_read(4'd1, d); check("lb_rx_empty", {31'd0, d[0]}, 32'd1);
      repeat (20) @(negedge clk);
      lb_watch = 1'b0;
      check("lb_txd_high", lb_low_cnt, 32'd0);
      bus_write(4'd3, 32'h0, 4'b0001);

      // TX overflow with transmitter disabled
      for (int i = 0; i < 17; i++) bus_write(4'd0, 32'(i), 4'b0001);
      bus_read(4'd1, d); check("ovf_status", d, 32'h89);
      bus_read(4'd6, d); check("ovf_levels", d, 32'h0010_0000);
      bus_write(4'd1, 32'h80, 4'b0001);
      bus_read(4'd1, d); check("ovf_w1c", d, 32'h09);
      bus_write(4'd3, 32'h20, 4'b0001);
      bus_read(4'd6, d); check("tx_flush", d, 32'd0);

      // Glitch rejection and framing error, BRR=15
      bus_write(4'd2, 32'd15, 4'b0011);
      bus_write(4'd3, 32'h2, 4'b0001);
      @(negedge clk) rxd = 1'b0;
      repeat (5) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      bus_read(4'd6, d); check("glitch_levels", d, 32'd0);
      bus_read(4'd1, d); check("glitch_status", d, 32'h15);
      send_frame(8'h3C, 1'b0, 16);
      bus_read(4'd1, d); check("fe_status", d, 32'h35);
      bus_read(4'd6, d); check("fe_levels", d, 32'd0);
      bus_write(4'd4, 32'h4, 4'b0001);
      check("irq_err_lat0", {31'd0, irq}, 32'd0);
      @(posedge clk); #1;
      check("irq_err_lat1", {31'd0, irq}, 32'd1);
      bus_write(4'd1, 32'h20, 4'b0001);
      bus_write(4'd4, 32'h0, 4'b0001);

      // RX threshold interrupt and single pop on held oe
      bus_write(4'd5, 32'd2, 4'b0001);
      bus_write(4'd4, 32'h1, 4'b0001);
      send_frame(8'h96, 1'b1, 16); exp_q.push_back(8'h96);
      bus_read(4'd6, d); check("thr_level1", d, 32'd1);
      check("thr_irq_below", {31'd0, irq}, 32'd0);
      send_frame(8'h3C, 1'b1, 16); exp_q.push_back(8'h3C);
      @(posedge clk); #1;
      check("thr_irq", {31'd0, irq}, 32'd1);
      @(negedge clk);
      bus.cs = 1'b1; bus.oe = 1'b1; bus.addr = 4'd0;
      #1 d = bus.data_out;
      check("hold_data", d, (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hxxxx_xxxx);
      repeat (5) @(posedge clk);
      #1 bus.cs = 1'b0; bus.oe = 1'b0;
      check("hold_irq", {31'd0, irq}, 32'd0);
      bus_read(4'd6, d); check("hold_levels", d, 32'd1);
      sb_read("thr_data1");

      // Asynchronous reset in the middle of a TX frame
      bus_write(4'd3, 32'h1, 4'b0001);
      bus_write(4'd0, 32'h00, 4'b0001);
      bus_write(4'd0, 32'h11, 4'b0001);
      repeat (20) @(posedge clk);
      #2 check("midframe_txd", {31'd0, txd}, 32'd0);
      rst = 1'b1;
      #1 check("async_rst_txd", {31'd0, txd}, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus_read(4'd1, d); check("post_rst_status", d, 32'h15);
      bus_read(4'd6, d); check("post_rst_levels", d, 32'd0);
      bus_read(4'd2, d); check("post_rst_brr", d, 32'd0);
      bus_read(4'd3, d); check("post_rst_ctrl", d, 32'd0);
      check("sb_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_fifo_periph.md
Name: uart_fifo_periph

Overview:
- Memory-mapped UART peripheral for the VexRiscv I/O-controller bus; successor to the single-byte serial port.
- Adds parametrised TX/RX FIFOs, selectable 1/2 stop bits, RX glitch rejection, internal loopback, sticky error flags and a maskable interrupt.
- Bus timing matches the existing peripheral block: combinational read data, strobed byte writes.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO; power of two, ≥2.
- BRR_W, 16, baud divisor width; one bit time = BRR+1 clocks.
- CNT_W, $clog2(FIFO_DEPTH)+1, FIFO level counter width (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cs  in  1  block select
- oe  in  1  read enable
- wstrb  in  4  byte write strobes
- addr  in  4  word register address
- data_in  in  32  write data
- data_out  out  32  read data; combinational; 0 unless cs&&oe
- rxd  in  1  serial input (asynchronous)
- txd  out  1  serial output; idle high
- irq  out  1  level interrupt

Behaviour:
- Reset: all registers, FIFOs, pointers and flags = 0; BRR = 0; txd = 1; irq = 0; RX FSM = IDLE; TX FSM = IDLE.
- Register map (addr):
  - 0 DATA. Write (wstrb[0]) pushes data_in[7:0] to the TX FIFO. Read returns the RX FIFO head (0 if empty). Pop occurs on the first cycle of a read: cs&&oe&&addr==0 && !rd_q, where rd_q is that term registered. A held oe pops once.
  - 1 STATUS (read):
    - [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full
    - [4] tx_idle (TX FIFO empty and shifter idle)
    - [5] fe, [6] rx_ovr, [7] tx_ovf
    - Writing 1 to bits 5..7 clears them (W1C).
  - 2 BRR. Byte-strobed write; read zero-extended.
  - 3 CTRL:
    - [0] tx_en, [1] rx_en, [2] two_stop, [3] loopback
    - [4] rx_flush, [5] tx_flush: write-1 self-clearing, read 0; empty the FIFO in the next cycle.
  - 4 IRQ_EN: [0] rx_thr, [1] tx_empty, [2] err.
  - 5 RX_THR: [CNT_W-1:0].
  - 6 LEVELS (read): [15:0] rx count, [31:16] tx count.
  - Others read 0; writes ignored.
- FIFO rules:
  - Full/empty use the current-cycle count. A same-cycle pop does not make room for a push.
  - Push to full TX FIFO: dropped, tx_ovf set.
  - Received byte with RX FIFO full: dropped, rx_ovr set.
  - Pointers wrap modulo FIFO_DEPTH.
  - Flush wins over a same-cycle push.
- TX FSM: IDLE → START → DATA(8, LSB first) → STOP(1 or 2) → IDLE.
  - Leaves IDLE when tx_en and the FIFO is non-empty; that edge pops the FIFO.
  - A write at edge N into an empty FIFO with idle shifter gives txd low from edge N+1.
  - Each bit is held BRR+1 clocks.
  - Clearing tx_en mid-frame finishes the current frame, then halts.
  - Back-to-back frames have no idle gap.
- RX input: rxd passes through a 2-flop synchroniser. With loopback=1 the RX input is the internal TX serial bit and the txd pin is held 1.
- RX FSM: IDLE → START → DATA → STOP (→ BREAK) → IDLE.
  - IDLE: a synchronised falling edge, with rx_en=1, enters START.
  - START: after BRR>>1 clocks, sample. If high, the glitch is rejected and the FSM returns to IDLE; otherwise go to DATA.
  - DATA: sample every BRR+1 clocks, 8 bits.
  - STOP: sample after BRR+1 clocks. If high, push the byte. If low, set fe, discard the byte and go to BREAK.
  - BREAK: wait for the input high, then IDLE.
  - Only the first stop bit is checked in RX.
- BRR writes take effect at the next bit-counter reload; the current bit is unaffected.
- Clearing rx_en forces RX to IDLE immediately; the partial byte is discarded.
- irq (registered, one-cycle latency) = (IRQ_EN[0] && RX_THR≠0 && rx_count≥RX_THR) | (IRQ_EN[1] && tx_empty) | (IRQ_EN[2] && (fe|rx_ovr|tx_ovf)).
- Async reset mid-frame: txd goes to 1 immediately and all FIFO contents are lost.

Test Plan:
- BRR=3, tx_en=1, write 0xA5 → txd low from next edge, then bits 1,0,1,0,0,1,0,1 each 4 clocks, stop high 4 clocks; tx_idle=1 after 40 clocks.
- loopback=1, rx_en=1, tx_en=1, BRR=7, write 0x00/0x5A/0xFF → LEVELS rx=3; three DATA reads return 0x00, 0x5A, 0xFF; rx_empty=1; txd pin stays 1 throughout.
- FIFO_DEPTH=16, tx_en=0, 17 DATA writes → tx_full=1, tx_ovf=1, tx count=16; W1C 0x80 clears tx_ovf.
- BRR=15, rxd low pulse of 5 clocks → no byte, rx count 0; full frame with stop bit low → fe=1, rx count 0; IRQ_EN=4 → irq=1 one cycle later.
- RX_THR=2, IRQ_EN=1, receive 2 bytes → irq=1; hold oe on DATA for 5 cycles → rx count drops by exactly 1 and irq=0.
- Assert rst mid-TX frame → txd=1 asynchronously; all STATUS/LEVELS = reset values after release.
